cpu_sequencer: RTL and testbench

- Multi-cycle control FSM that sequences the existing MIPS datapath through five steps: fetch, decode, execute, memory and writeback.
- Holds the instruction register (IR), which feeds DECODE.
- Runs the instruction-memory and data-memory req/ready handshakes.
- Gates the register-file write enable and the PC update so each instruction commits exactly once.
- Counts retired instructions and halts on an exit syscall or on a fetch timeout.

---
 rtl/cpu_sequencer_pkg.sv | 24 ++
 rtl/cpu_sequencer_fetch_timer.sv | 36 +++
 rtl/cpu_sequencer.sv | 140 ++++++++++++++
 tb/tb_cpu_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared types and constants for the multi-cycle MIPS control sequencer.
// - state_t   : sequencer state encoding (also visible on the debug port)
// - W_MEM_CMD : width of the data-memory command bus
// - MEM_*     : data-memory command codes (MEM_NOP means "no access")
`timescale 1ns/1ps
package cpu_sequencer_pkg;

    localparam int W_MEM_CMD = 2;

    localparam logic [W_MEM_CMD-1:0] MEM_NOP = 2'd0;
    localparam logic [W_MEM_CMD-1:0] MEM_LW  = 2'd1;
    localparam logic [W_MEM_CMD-1:0] MEM_SW  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

endpackage

// File: rtl/cpu_sequencer_fetch_timer.sv
// Fetch wait counter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_clear     : zero the counter (takes priority over i_enable)
//   i_enable    : count one more wait cycle
//   o_expired   : this wait cycle is the FETCH_TIMEOUT-th one
`timescale 1ns/1ps
module seq_fetch_timer #(
    parameter int FETCH_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = $clog2(FETCH_TIMEOUT + 1);
    // The counter holds completed waits, so the current wait is number r_cnt+1.
    localparam logic [CW-1:0] LAST_WAIT = CW'(FETCH_TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expired = i_enable && (r_cnt == LAST_WAIT);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the MIPS datapath:
// FETCH -> DECODE -> EXEC -> [MEM] -> WB, holding the instruction register,
// running the imem/dmem req/ready handshakes and committing each instruction
// exactly once (single reg_wen / pc_wen pulse in WB).
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   imem_req/imem_ready/imem_rdata  : instruction fetch handshake
//   ir                              : latched instruction to DECODE
//   dec_mem_cmd/dec_reg_wen/dec_syscall : DECODE results for ir
//   exit_req                        : $v0 holds the exit code
//   dmem_req/dmem_cmd/dmem_ready    : data memory handshake
//   reg_wen, pc_wen                 : commit strobes
//   retired                         : retired-instruction count (wraps)
//   halted, fault                   : sticky halt / fetch-timeout flags
//   state                           : current state, debug only
`timescale 1ns/1ps
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int W_INST        = 32,
    parameter int W_CNT         = 32,
    parameter int FETCH_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    input  logic                 imem_ready,
    input  logic [W_INST-1:0]    imem_rdata,
    output logic [W_INST-1:0]    ir,
    input  logic [W_MEM_CMD-1:0] dec_mem_cmd,
    input  logic                 dec_reg_wen,
    input  logic                 dec_syscall,
    input  logic                 exit_req,
    output logic                 dmem_req,
    output logic [W_MEM_CMD-1:0] dmem_cmd,
    input  logic                 dmem_ready,
    output logic                 reg_wen,
    output logic                 pc_wen,
    output logic [W_CNT-1:0]     retired,
    output logic                 halted,
    output logic                 fault,
    output logic [2:0]           state
);

    state_t               r_state;
    logic [W_INST-1:0]    r_ir;
    logic [W_CNT-1:0]     r_retired;
    logic [W_MEM_CMD-1:0] r_dmem_cmd;
    logic                 r_fault;

    logic w_fetch_wait;
    logic w_timer_clear;
    logic w_timeout;

    // Any cycle outside FETCH, or a successful fetch, restarts the wait count.
    assign w_fetch_wait  = (r_state == S_FETCH) && !imem_ready;
    assign w_timer_clear = (r_state != S_FETCH) || imem_ready;

    seq_fetch_timer #(
        .FETCH_TIMEOUT (FETCH_TIMEOUT)
    ) u_fetch_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_timer_clear),
        .i_enable  (w_fetch_wait),
        .o_expired (w_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ir       <= '0;
            r_retired  <= '0;
            r_dmem_cmd <= MEM_NOP;
            r_fault    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    // A ready arriving on the last allowed wait cycle wins.
                    if (imem_ready) begin
                        r_ir    <= imem_rdata;
                        r_state <= S_DECODE;
                    end else if (w_timeout) begin
                        r_fault <= 1'b1;
                        r_state <= S_HALT;
                    end
                end
                S_DECODE: begin
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    // A syscall without the exit code falls through as a NOP-class op.
                    if (dec_syscall && exit_req) begin
                        r_state <= S_HALT;
                    end else if (dec_mem_cmd == MEM_NOP) begin
                        r_state <= S_WB;
                    end else begin
                        r_dmem_cmd <= dec_mem_cmd;
                        r_state    <= S_MEM;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        r_dmem_cmd <= MEM_NOP;
                        r_state    <= S_WB;
                    end
                end
                S_WB: begin
                    r_retired <= r_retired + W_CNT'(1);
                    r_state   <= S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    // Unreachable encoding: park safely and flag it.
                    r_fault    <= 1'b1;
                    r_dmem_cmd <= MEM_NOP;
                    r_state    <= S_HALT;
                end
            endcase
        end
    end

    // Moore decodes; they drop as soon as reset forces r_state to S_IDLE.
    assign imem_req = (r_state == S_FETCH);
    assign dmem_req = (r_state == S_MEM);
    assign reg_wen  = (r_state == S_WB) && dec_reg_wen;
    assign pc_wen   = (r_state == S_WB);
    assign halted   = (r_state == S_HALT);
    assign fault    = r_fault;
    assign dmem_cmd = r_dmem_cmd;
    assign ir       = r_ir;
    assign retired  = r_retired;
    assign state    = r_state;

endmodule

// File: tb/tb_cpu_sequencer.sv
`timescale 1ns/1ps
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ready;
    logic [31:0] imem_rdata, ir;
    logic [1:0]  dec_mem_cmd, dmem_cmd;
    logic        dec_reg_wen, dec_syscall, exit_req;
    logic        dmem_req, dmem_ready, reg_wen, pc_wen, halted, fault;
    logic [31:0] retired;
    logic [2:0]  state;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .ir          (ir),
        .dec_mem_cmd (dec_mem_cmd),
        .dec_reg_wen (dec_reg_wen),
        .dec_syscall (dec_syscall),
        .exit_req    (exit_req),
        .dmem_req    (dmem_req),
        .dmem_cmd    (dmem_cmd),
        .dmem_ready  (dmem_ready),
        .reg_wen     (reg_wen),
        .pc_wen      (pc_wen),
        .retired     (retired),
        .halted      (halted),
        .fault       (fault),
        .state       (state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [2:0]  st;
        logic        imr;
        logic        dmr;
        logic [1:0]  cmd;
        logic        rw;
        logic        pw;
        logic        hl;
        logic        ft;
        logic [31:0] ir;
        logic [31:0] ret;
    } obs_t;

    // Architectural model state (what the outputs must show this cycle).
    obs_t        exp_q[$];
    logic [31:0] m_ir, m_ret;
    logic [1:0]  m_cmd;
    logic        m_halted, m_fault;

    function automatic void expect_cycle(input logic [2:0] st, input logic imr,
                                         input logic dmr, input logic rw, input logic pw);
        obs_t e;
        e.st = st; e.imr = imr; e.dmr = dmr; e.cmd = m_cmd; e.rw = rw; e.pw = pw;
        e.hl = m_halted; e.ft = m_fault; e.ir = m_ir; e.ret = m_ret;
        exp_q.push_back(e);
    endfunction

    function automatic obs_t observe();
        obs_t a;
        a.st = state; a.imr = imem_req; a.dmr = dmem_req; a.cmd = dmem_cmd;
        a.rw = reg_wen; a.pw = pc_wen; a.hl = halted; a.ft = fault;
        a.ir = ir; a.ret = retired;
        return a;
    endfunction

    // Single per-cycle compare against the model, on the inactive edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e;
            obs_t a;
            e = exp_q.pop_front();
            a = observe();
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t got=%h want=%h (st,imr,dmr,cmd,rw,pw,hl,ft,ir,ret)",
                         $time, a, e);
            end
        end
    end

    // Activity monitor used by the hand-computed checks.
    int cyc = 0;
    int fetch_t[$];
    logic prev_imr = 1'b0;
    int dmr_cnt = 0;
    int imr_cnt = 0;
    always @(negedge clk) begin
        cyc++;
        if (imem_req && !prev_imr) fetch_t.push_back(cyc);
        prev_imr = imem_req;
        if (dmem_req) dmr_cnt++;
        if (imem_req) imr_cnt++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ir = '0; m_ret = '0; m_cmd = MEM_NOP; m_halted = 1'b0; m_fault = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ready = 0; imem_rdata = 0; dec_mem_cmd = 0; dec_reg_wen = 0;
        dec_syscall = 0; exit_req = 0; dmem_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_cycle(3'd0, 0, 0, 0, 0);
        step();
    endtask

    // One instruction as a transaction: wf fetch waits, wd data waits.
    task automatic run_inst(input int wf, input int wd, input logic [1:0] cmd,
                            input bit rw, input bit sy, input bit ex,
                            input logic [31:0] word, input bit abort_in_mem);
        bit do_halt;
        for (int k = 0; k <= wf; k++) begin
            imem_ready  = (k == wf);
            imem_rdata  = (k == wf) ? word : $urandom;
            dmem_ready  = 1'($urandom);
            dec_mem_cmd = 2'($urandom);
            dec_reg_wen = 1'($urandom);
            dec_syscall = 1'($urandom);
            exit_req    = 1'($urandom);
            expect_cycle(3'd1, 1, 0, 0, 0);
            if (k == wf) m_ir = word;
            step();
        end
        imem_ready  = 1'($urandom);
        imem_rdata  = $urandom;
        dmem_ready  = 1'($urandom);
        dec_mem_cmd = cmd; dec_reg_wen = rw; dec_syscall = sy; exit_req = ex;
        expect_cycle(3'd2, 0, 0, 0, 0);
        step();
        do_halt = sy && ex;
        expect_cycle(3'd3, 0, 0, 0, 0);
        if (do_halt) m_halted = 1'b1;
        else if (cmd != MEM_NOP) m_cmd = cmd;
        step();
        if (do_halt) return;
        if (cmd != MEM_NOP) begin
            for (int k = 0; k <= wd; k++) begin
                dmem_ready = abort_in_mem ? 1'b0 : (k == wd);
                imem_ready = 1'($urandom);
                expect_cycle(3'd4, 0, 1, 0, 0);
                if (abort_in_mem) begin
                    @(negedge clk);
                    #1;
                    return;
                end
                if (k == wd) m_cmd = MEM_NOP;
                step();
            end
        end
        dmem_ready = 1'($urandom);
        imem_ready = 1'($urandom);
        expect_cycle(3'd5, 0, 0, rw, 1);
        m_ret = m_ret + 1;
        step();
    endtask

    task automatic halt_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            imem_ready = 1'($urandom);
            dmem_ready = 1'($urandom);
            expect_cycle(3'd6, 0, 0, 0, 0);
            step();
        end
    endtask

    initial begin
        model_reset();
        imem_ready = 0; imem_rdata = 0; dec_mem_cmd = 0; dec_reg_wen = 0;
        dec_syscall = 0; exit_req = 0; dmem_ready = 0;

        // Reset state.
        @(posedge clk);
        #1;
        check("rst_state",   32'(state),    32'd0);
        check("rst_retired", retired,       32'd0);
        check("rst_ir",      ir,            32'd0);
        check("rst_reqs",    32'({imem_req, dmem_req, reg_wen, pc_wen}), 32'd0);
        check("rst_flags",   32'({halted, fault}), 32'd0);
        check("rst_dmemcmd", 32'(dmem_cmd), 32'(MEM_NOP));
        do_reset();
        fetch_t.delete();

        // ADD, zero-wait.
        run_inst(0, 0, MEM_NOP, 1, 0, 0, 32'h012A4020, 0);
        check("add_retired", retired, 32'd1);
        check("add_ir",      ir,      32'h012A4020);
        check("add_no_dmem", 32'(dmr_cnt), 32'd0);

        // LW with 3 data wait cycles.
        dmr_cnt = 0;
        run_inst(0, 3, MEM_LW, 1, 0, 0, 32'h8D090004, 0);
        check("lw_dmem_req_cycles", 32'(dmr_cnt), 32'd4);

        // SW-class, no register write.
        run_inst(0, 1, MEM_SW, 0, 0, 0, 32'hAD090008, 0);
        check("sw_retired", retired, 32'd3);
        check("add_period", 32'(fetch_t[1] - fetch_t[0]), 32'd4);
        check("lw_period",  32'(fetch_t[2] - fetch_t[1]), 32'd8);

        // Randomized instruction mix, including non-exit syscalls.
        for (int i = 0; i < 40; i++) begin
            int wf, wd;
            bit sy, ex;
            wf = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 30) : $urandom_range(0, 3);
            wd = $urandom_range(0, 4);
            sy = ($urandom_range(0, 3) == 0);
            ex = sy ? 1'b0 : 1'($urandom);
            run_inst(wf, wd, 2'($urandom_range(0, 3)), 1'($urandom), sy, ex, $urandom, 0);
        end
        check("rand_retired", retired, 32'd43);

        // Exit syscall after 5 retired instructions.
        do_reset();
        for (int i = 0; i < 5; i++)
            run_inst($urandom_range(0, 2), $urandom_range(0, 2), 2'($urandom_range(0, 2)),
                     1'($urandom), 0, 0, $urandom, 0);
        run_inst(0, 0, MEM_NOP, 1, 1, 1, 32'h0000000C, 0);
        imr_cnt = 0;
        halt_cycles(25);
        check("exit_retired", retired, 32'd5);
        check("exit_halted",  32'(halted), 32'd1);
        check("exit_no_fetch", 32'(imr_cnt), 32'd0);

        // Fetch timeout: ready never arrives.
        do_reset();
        for (int k = 0; k < 255; k++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            expect_cycle(3'd1, 1, 0, 0, 0);
            if (k == 254) begin m_fault = 1'b1; m_halted = 1'b1; end
            step();
        end
        halt_cycles(10);
        check("timeout_fault",  32'(fault),  32'd1);
        check("timeout_halted", 32'(halted), 32'd1);

        // Ready on the 255th wait cycle wins over the timeout.
        do_reset();
        run_inst(254, 0, MEM_NOP, 1, 0, 0, 32'h01095020, 0);
        check("late_ready_fault",   32'(fault), 32'd0);
        check("late_ready_retired", retired,    32'd1);

        // Reset asserted in the middle of a data access.
        run_inst(0, 0, MEM_LW, 1, 0, 0, 32'h8D0A0000, 0);
        run_inst(0, 5, MEM_LW, 1, 0, 0, 32'h8D0B0004, 1);
        rst_n = 1'b0;
        #1;
        check("abort_dmem_req", 32'(dmem_req), 32'd0);
        check("abort_state",    32'(state),    32'd0);
        check("abort_retired",  retired,       32'd0);
        do_reset();
        run_inst(0, 0, MEM_NOP, 1, 0, 0, 32'h012A4020, 0);
        check("post_abort_retired", retired, 32'd1);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
